// File: rtl/memory_bus_master.sv
// Single-word initiator for the active-low register-file bus with host valid/ready request/response ports.
// Optional read bursts are enabled by defining MEM_MASTER_BURST_EN.
module memory_bus_master #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_DEPTH    = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_sn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_last,
    output logic                  memory_enable_n,
    output logic                  memory_write_n,
    output logic                  memory_read_n,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0] memory_data_in,
    input  logic [DATA_WIDTH-1:0] memory_data_out
);

    typedef enum logic [2:0] {IDLE, WRITE, RSTROBE, RWAIT, RESP} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next, addr_inc;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  is_write_reg, is_write_next;
    logic                  err_reg, err_next;
    logic [1:0]            lat_cnt_reg, lat_cnt_next;
    logic                  last_beat, handshake;

    logic                  enable_n_reg, enable_n_next;
    logic                  write_n_reg, write_n_next;
    logic                  read_n_reg, read_n_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic                  rsp_last_reg, rsp_last_next;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} >= DEPTH_L;
    endfunction

    assign addr_inc  = addr_reg + ADDR_WIDTH'(1);
    assign handshake = (state_reg == RESP) && rsp_valid_reg && rsp_ready;

`ifdef MEM_MASTER_BURST_EN
    logic [3:0] beats_reg, beats_next;

    always_ff @(posedge clock or negedge reset_sn) begin
        if (!reset_sn) beats_reg <= '0;
        else           beats_reg <= beats_next;
    end

    always_comb begin
        beats_next = beats_reg;
        if (state_reg == IDLE && req_valid)
            beats_next = req_write ? 4'd0 : req_len;
        else if (handshake && !last_beat)
            beats_next = beats_reg - 4'd1;
    end

    assign last_beat = (beats_reg == 4'd0);
`else
    logic unused_req_len;
    assign unused_req_len = ^req_len;
    assign last_beat      = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_sn) begin
        if (!reset_sn) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            is_write_reg <= 1'b0;
            err_reg      <= 1'b0;
            lat_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            is_write_reg <= is_write_next;
            err_reg      <= err_next;
            lat_cnt_reg  <= lat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        is_write_next = is_write_reg;
        err_next      = err_reg;
        lat_cnt_next  = lat_cnt_reg;
        case (state_reg)
            IDLE: if (req_valid) begin
                addr_next     = req_addr;
                wdata_next    = req_wdata;
                is_write_next = req_write;
                err_next      = out_of_range(req_addr);
                if (out_of_range(req_addr)) state_next = RESP;
                else                        state_next = req_write ? WRITE : RSTROBE;
            end
            WRITE:   state_next = RESP;
            RSTROBE: begin
                lat_cnt_next = 2'(READ_LATENCY - 1);
                state_next   = RWAIT;
            end
            RWAIT: begin
                if (lat_cnt_reg == 2'd0) state_next = RESP;
                else                     lat_cnt_next = lat_cnt_reg - 2'd1;
            end
            RESP: if (handshake) begin
                if (last_beat) begin
                    state_next = IDLE;
                end else begin
                    addr_next  = addr_inc;
                    err_next   = out_of_range(addr_inc);
                    state_next = out_of_range(addr_inc) ? RESP : RSTROBE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered one cycle behind the state that requests them,
    // so the first RESP cycle is where the (already valid) read data is captured.
    always_comb begin
        enable_n_next  = 1'b1;
        write_n_next   = 1'b1;
        read_n_next    = 1'b1;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_last_next  = rsp_last_reg;
        case (state_reg)
            WRITE: begin
                enable_n_next  = 1'b0;
                write_n_next   = 1'b0;
                mem_addr_next  = addr_reg;
                mem_wdata_next = wdata_reg;
            end
            RSTROBE: begin
                enable_n_next = 1'b0;
                read_n_next   = 1'b0;
                mem_addr_next = addr_reg;
            end
            RESP: begin
                if (!rsp_valid_reg) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = err_reg;
                    rsp_rdata_next = (err_reg || is_write_reg) ? '0 : memory_data_out;
                    rsp_last_next  = last_beat;
                end else if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_err_next   = 1'b0;
                    rsp_last_next  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_sn) begin
        if (!reset_sn) begin
            enable_n_reg  <= 1'b1;
            write_n_reg   <= 1'b1;
            read_n_reg    <= 1'b1;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            rsp_last_reg  <= 1'b0;
        end else begin
            enable_n_reg  <= enable_n_next;
            write_n_reg   <= write_n_next;
            read_n_reg    <= read_n_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_last_reg  <= rsp_last_next;
        end
    end

    assign req_ready       = (state_reg == IDLE);
    assign rsp_valid       = rsp_valid_reg;
    assign rsp_rdata       = rsp_rdata_reg;
    assign rsp_err         = rsp_err_reg;
    assign rsp_last        = rsp_last_reg;
    assign memory_enable_n = enable_n_reg;
    assign memory_write_n  = write_n_reg;
    assign memory_read_n   = read_n_reg;
    assign memory_address  = mem_addr_reg;
    assign memory_data_in  = mem_wdata_reg;

endmodule

// File: tb/tb_memory_bus_master.sv
// Directed bench for memory_bus_master with a one-cycle-latency register-file responder model.
module tb_memory_bus_master;

    logic        clock = 1'b0;
    logic        reset_sn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [3:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_last;
    logic        memory_enable_n, memory_write_n, memory_read_n;
    logic [7:0]  memory_address;
    logic [15:0] memory_data_in;
    logic [15:0] memory_data_out = '0;

    int total = 0;
    int bad = 0;

    memory_bus_master dut (
        .clock(clock), .reset_sn(reset_sn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .memory_enable_n(memory_enable_n), .memory_write_n(memory_write_n),
        .memory_read_n(memory_read_n), .memory_address(memory_address),
        .memory_data_in(memory_data_in), .memory_data_out(memory_data_out)
    );

    always #5 clock = ~clock;

    // Responder: registered read data, zero outside a read window.
    logic [15:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clock) begin
        if (!memory_enable_n && !memory_write_n) mem[memory_address] <= memory_data_in;
        memory_data_out <= (!memory_enable_n && !memory_read_n) ? mem[memory_address] : 16'h0;
    end

    // Bus monitor, sampled mid-cycle.
    int          wr_cnt = 0, rd_cnt = 0, viol_cnt = 0, valid_cnt = 0;
    logic [7:0]  wr_addr_seen = '0, rd_addr_seen = '0;
    logic [15:0] wr_data_seen = '0;
    logic        prev_low = 1'b0;
    always @(negedge clock) begin
        if (!memory_enable_n && !memory_write_n) begin
            wr_cnt++; wr_addr_seen = memory_address; wr_data_seen = memory_data_in;
        end
        if (!memory_enable_n && !memory_read_n) begin
            rd_cnt++; rd_addr_seen = memory_address;
        end
        if (prev_low && !memory_enable_n) viol_cnt++;
        prev_low = !memory_enable_n;
        if (rsp_valid) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic w, input logic [7:0] a, input logic [15:0] d, input logic [3:0] len);
        req_write = w; req_addr = a; req_wdata = d; req_len = len;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (rsp_valid) begin lat = i; break; end
        end
    endtask

    task automatic take_rsp();
        $display("txn rsp rdata=%0h err=%0b last=%0b", rsp_rdata, rsp_err, rsp_last);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    // Single-beat request with full response check.
    task automatic txn(input string tag, input logic w, input logic [7:0] a, input logic [15:0] d,
                       input int exp_lat, input logic [15:0] exp_rdata, input logic exp_err,
                       input int exp_wr, input int exp_rd);
        int lat, wr0, rd0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        check({tag, "_ready"}, req_ready, 1);
        $display("txn %s write=%0b addr=%0h wdata=%0h", tag, w, a, d);
        send(w, a, d, 4'd0);
        wait_rsp(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, rsp_err, exp_err);
        check({tag, "_last"}, rsp_last, 1);
        check({tag, "_wrstb"}, wr_cnt - wr0, exp_wr);
        check({tag, "_rdstb"}, rd_cnt - rd0, exp_rd);
        take_rsp();
        check({tag, "_done"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int lat, rd0, v0;
        logic [19:0] snap;

        #12;
        check("rst_strobes", {memory_enable_n, memory_write_n, memory_read_n}, 3'b111);
        check("rst_bus", {memory_address, memory_data_in}, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_last, rsp_rdata}, 0);
        check("rst_ready", req_ready, 1);
        @(posedge clock); #1;
        reset_sn = 1'b1;
        @(posedge clock); #1;

        txn("wr2", 1'b1, 8'd2, 16'h1234, 2, 16'h0, 1'b0, 1, 0);
        check("wr2_addr", wr_addr_seen, 8'd2);
        check("wr2_data", wr_data_seen, 16'h1234);
        txn("rd2", 1'b0, 8'd2, 16'h0, 3, 16'h1234, 1'b0, 0, 1);
        check("rd2_addr", rd_addr_seen, 8'd2);
        txn("wr9", 1'b1, 8'd9, 16'hBEEF, 2, 16'h0, 1'b0, 1, 0);
        txn("rd9", 1'b0, 8'd9, 16'h0, 3, 16'hBEEF, 1'b0, 0, 1);
        txn("wr8", 1'b1, 8'd8, 16'h0808, 2, 16'h0, 1'b0, 1, 0);
        txn("rd12", 1'b0, 8'd12, 16'h0, 1, 16'h0, 1'b1, 0, 0);
        txn("wr10", 1'b1, 8'd10, 16'hAAAA, 1, 16'h0, 1'b1, 0, 0);
        check("hold_addr", memory_address, 8'd8);
        check("hold_data", memory_data_in, 16'h0808);

        // Read at addr 8 with req_len=2.
        rd0 = rd_cnt;
        $display("txn burst read addr=8 len=2");
        send(1'b0, 8'd8, 16'h0, 4'd2);
        wait_rsp(lat);
        check("b0_lat", lat, 3);
        check("b0_rdata", rsp_rdata, 16'h0808);
        check("b0_err", rsp_err, 0);
`ifdef MEM_MASTER_BURST_EN
        check("b0_last", rsp_last, 0);
        take_rsp();
        wait_rsp(lat);
        check("b1_lat", lat, 3);
        check("b1_rdata", rsp_rdata, 16'hBEEF);
        check("b1_last", rsp_last, 0);
        take_rsp();
        wait_rsp(lat);
        check("b2_lat", lat, 1);
        check("b2_err_last", {rsp_err, rsp_last}, 2'b11);
        check("b2_rdata", rsp_rdata, 0);
        take_rsp();
        check("b_rdstb", rd_cnt - rd0, 2);
`else
        check("b0_last", rsp_last, 1);
        take_rsp();
        check("b_rdstb", rd_cnt - rd0, 1);
`endif
        check("b_idle", {rsp_valid, req_ready}, 2'b01);

        // Backpressure on a read response.
        $display("txn backpressure read addr=2");
        send(1'b0, 8'd2, 16'h0, 4'd0);
        wait_rsp(lat);
        check("bp_lat", lat, 3);
        snap = {rsp_valid, rsp_err, rsp_last, 1'b0, rsp_rdata};
        check("bp_rdata", rsp_rdata, 16'h1234);
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("bp_hold", {rsp_valid, rsp_err, rsp_last, 1'b0, rsp_rdata}, snap);
            check("bp_strobes", {memory_enable_n, memory_write_n, memory_read_n}, 3'b111);
        end
        check("bp_nobus", rd_cnt - rd0, 0);
        take_rsp();
        check("bp_idle", {rsp_valid, req_ready}, 2'b01);

        // Reset while waiting for read data.
        $display("txn read addr=2 with reset in RWAIT");
        send(1'b0, 8'd2, 16'h0, 4'd0);
        @(posedge clock); #1;
        check("rr_strobe_low", {memory_enable_n, memory_read_n}, 2'b00);
        v0 = valid_cnt;
        reset_sn = 1'b0;
        #1;
        check("rr_strobes", {memory_enable_n, memory_write_n, memory_read_n}, 3'b111);
        repeat (2) @(posedge clock);
        #2 reset_sn = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("rr_novalid", valid_cnt - v0, 0);
        txn("wr3", 1'b1, 8'd3, 16'h5A5A, 2, 16'h0, 1'b0, 1, 0);
        txn("rd3", 1'b0, 8'd3, 16'h0, 3, 16'h5A5A, 1'b0, 0, 1);

        check("no_back_to_back", viol_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
